// File: rtl/ir_packet_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ir_packet_decoder
//  Description : Recovers the 4-bit drive command from the modulated IR pulse
//                stream (carrier gated by a burst envelope). A packet is a
//                start burst, a car-select burst and four data bursts
//                (COMMAND[0..3]); a long burst encodes 1, a short burst 0.
//  Ports       : CLK          in   system clock
//                RESET        in   synchronous, active-high reset
//                IR_IN        in   raw modulated IR stream (asynchronous)
//                COMMAND      out  [3:0] last valid command
//                                  [0] right [1] left [2] backward [3] forward
//                PACKET_VALID out  one-cycle strobe, COMMAND updated this cycle
//                PACKET_ERROR out  one-cycle strobe, malformed packet dropped
//                GOOD_COUNT   out  [7:0] saturating good-packet count (opt.)
//                ERROR_COUNT  out  [7:0] saturating bad-packet count (opt.)
//                BUSY         out  high while a packet is being decoded
//  Options     : define IR_DECODER_STATS_EN to add GOOD_COUNT / ERROR_COUNT.
//  Revision    : 1.0 - initial release
// ============================================================================
module ir_packet_decoder #(
  parameter int CLKS_PER_TICK = 2500,
  parameter int ENV_HOLD      = 3750,
  parameter int START_MIN     = 80,
  parameter int START_MAX     = 96,
  parameter int SHORT_MIN     = 16,
  parameter int SHORT_MAX     = 28,
  parameter int LONG_MIN      = 36,
  parameter int LONG_MAX      = 52,
  parameter int GAP_MAX       = 60
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IR_IN,
  output logic [3:0] COMMAND,
  output logic       PACKET_VALID,
  output logic       PACKET_ERROR,
`ifdef IR_DECODER_STATS_EN
  output logic [7:0] GOOD_COUNT,
  output logic [7:0] ERROR_COUNT,
`endif
  output logic       BUSY
);

  localparam int TICK_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int ENV_W  = $clog2(ENV_HOLD + 1);

  localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(CLKS_PER_TICK - 1);
  localparam logic [ENV_W-1:0]  c_env_hold  = ENV_W'(ENV_HOLD);
  localparam logic [7:0]        c_start_min = 8'(START_MIN);
  localparam logic [7:0]        c_start_max = 8'(START_MAX);
  localparam logic [7:0]        c_short_min = 8'(SHORT_MIN);
  localparam logic [7:0]        c_short_max = 8'(SHORT_MAX);
  localparam logic [7:0]        c_long_min  = 8'(LONG_MIN);
  localparam logic [7:0]        c_long_max  = 8'(LONG_MAX);
  localparam logic [7:0]        c_gap_max   = 8'(GAP_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchroniser, envelope detector and timing counters
  // --------------------------------------------------------------------------
  logic              r_ir_meta;
  logic              r_ir_sync;
  logic [ENV_W-1:0]  r_env_timer;
  logic              r_env_d;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [7:0]        r_len;

  logic w_env;
  logic w_env_rise;
  logic w_env_fall;
  logic w_tick;

  assign w_env      = (r_env_timer != '0);
  assign w_env_rise = w_env & ~r_env_d;
  assign w_env_fall = ~w_env & r_env_d;
  assign w_tick     = (r_tick_cnt == c_tick_last);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ir_meta   <= 1'b0;
      r_ir_sync   <= 1'b0;
      r_env_timer <= '0;
      r_env_d     <= 1'b0;
      r_tick_cnt  <= '0;
      r_len       <= '0;
    end else begin
      r_ir_meta <= IR_IN;
      r_ir_sync <= r_ir_meta;

      // The hold time bridges the carrier low half-periods so one burst
      // produces a single continuous envelope pulse.
      if (r_ir_sync) begin
        r_env_timer <= c_env_hold;
      end else if (r_env_timer != '0) begin
        r_env_timer <= r_env_timer - ENV_W'(1);
      end
      r_env_d <= w_env;

      if (w_tick) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      end

      // Length restarts on either envelope edge, so it measures the current
      // burst while env is high and the current gap while env is low.
      if (w_env_rise || w_env_fall) begin
        r_len <= '0;
      end else if (w_tick && (r_len != 8'hFF)) begin
        r_len <= r_len + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Length classification (inclusive ranges)
  // --------------------------------------------------------------------------
  logic w_in_start;
  logic w_in_long;
  logic w_in_short;

  assign w_in_start = (r_len >= c_start_min) && (r_len <= c_start_max);
  assign w_in_long  = (r_len >= c_long_min)  && (r_len <= c_long_max);
  assign w_in_short = (r_len >= c_short_min) && (r_len <= c_short_max);

  // --------------------------------------------------------------------------
  // Packet FSM
  // --------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_idx;
  logic [2:0] w_idx_nxt;
  logic [3:0] r_shadow;
  logic [3:0] w_shadow_nxt;
  logic       w_err;
  logic [1:0] w_bit_sel;

  // Data fields sit at idx 2..5; adding 2 modulo 4 maps them to bits 0..3.
  assign w_bit_sel = r_idx[1:0] + 2'd2;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_shadow <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_shadow_nxt = r_shadow;
    w_err        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_env_rise) begin
          w_state_nxt = ST_BURST;
        end
      end

      ST_BURST: begin
        if (w_env_fall) begin
          if (r_idx == 3'd0) begin
            // A bad start burst is treated as noise and dropped silently.
            if (w_in_start) begin
              w_idx_nxt   = 3'd1;
              w_state_nxt = ST_GAP;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else if (w_in_start) begin
            // Start burst mid-packet: abandon the old packet, resync on it.
            w_err       = 1'b1;
            w_idx_nxt   = 3'd1;
            w_state_nxt = ST_GAP;
          end else if (r_idx == 3'd1) begin
            if (w_in_short) begin
              w_idx_nxt   = 3'd2;
              w_state_nxt = ST_GAP;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else if (w_in_long || w_in_short) begin
            w_shadow_nxt[w_bit_sel] = w_in_long;
            if (r_idx == 3'd5) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_idx_nxt   = r_idx + 3'd1;
              w_state_nxt = ST_GAP;
            end
          end else begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end

      ST_GAP: begin
        if (w_env_rise) begin
          w_state_nxt = ST_BURST;
        end else if (r_len > c_gap_max) begin
          w_err       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_state_nxt == ST_IDLE) begin
      w_idx_nxt = 3'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  logic [3:0] r_command;
  logic       r_valid;
  logic       r_error;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_command <= '0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_valid <= (r_state == ST_DONE);
      r_error <= w_err;
      if (r_state == ST_DONE) begin
        r_command <= r_shadow;
      end
    end
  end

  assign COMMAND      = r_command;
  assign PACKET_VALID = r_valid;
  assign PACKET_ERROR = r_error;
  assign BUSY         = (r_state != ST_IDLE);

`ifdef IR_DECODER_STATS_EN
  logic [7:0] r_good_cnt;
  logic [7:0] r_bad_cnt;

  // Counters advance on the same edge that raises the matching strobe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else begin
      if ((r_state == ST_DONE) && (r_good_cnt != 8'hFF)) begin
        r_good_cnt <= r_good_cnt + 8'd1;
      end
      if (w_err && (r_bad_cnt != 8'hFF)) begin
        r_bad_cnt <= r_bad_cnt + 8'd1;
      end
    end
  end

  assign GOOD_COUNT  = r_good_cnt;
  assign ERROR_COUNT = r_bad_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ir_packet_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ir_packet_decoder
//  Description : Directed self-checking bench for ir_packet_decoder. Timing
//                is scaled down (4 clocks per carrier tick, envelope hold of
//                1.5 ticks) so whole packets fit in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ir_packet_decoder;

  localparam int c_clks_per_tick = 4;
  localparam int c_env_hold      = 6;

  // Burst/gap lengths in carrier periods, chosen mid-range.
  localparam int c_start = 87;
  localparam int c_short = 21;
  localparam int c_long  = 43;
  localparam int c_gap   = 22;
  localparam int c_tail  = 20;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       IR_IN;
  logic [3:0] COMMAND;
  logic       PACKET_VALID;
  logic       PACKET_ERROR;
  logic       BUSY;
`ifdef IR_DECODER_STATS_EN
  logic [7:0] GOOD_COUNT;
  logic [7:0] ERROR_COUNT;
`endif

  ir_packet_decoder #(
    .CLKS_PER_TICK (c_clks_per_tick),
    .ENV_HOLD      (c_env_hold)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .IR_IN        (IR_IN),
    .COMMAND      (COMMAND),
    .PACKET_VALID (PACKET_VALID),
    .PACKET_ERROR (PACKET_ERROR),
`ifdef IR_DECODER_STATS_EN
    .GOOD_COUNT   (GOOD_COUNT),
    .ERROR_COUNT  (ERROR_COUNT),
`endif
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;

  // --------------------------------------------------------------------------
  // Strobe monitor
  // --------------------------------------------------------------------------
  int         cyc = 0;
  int         valid_cnt = 0;
  int         err_cnt = 0;
  int         both_cnt = 0;
  int         last_err_cyc = 0;
  logic [3:0] cmd_log[$];

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (PACKET_VALID) begin
      valid_cnt++;
      cmd_log.push_back(COMMAND);
    end
    if (PACKET_ERROR) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (PACKET_VALID && PACKET_ERROR) both_cnt++;
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < cmd_log.size()) return 32'(cmd_log[i]);
    return 32'hFFFF_FFFF;
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // --------------------------------------------------------------------------
  task automatic burst(input int n);
    for (int p = 0; p < n; p++) begin
      repeat (2) begin @(negedge CLK); IR_IN = 1'b1; end
      repeat (2) begin @(negedge CLK); IR_IN = 1'b0; end
    end
  endtask

  task automatic quiet(input int n);
    repeat (n * c_clks_per_tick) begin @(negedge CLK); IR_IN = 1'b0; end
  endtask

  // Everything after the start burst; bad_bit selects a data field whose
  // length is replaced by bad_len (-1 for none).
  task automatic send_data(input logic [3:0] cmd, input int bad_bit, input int bad_len);
    quiet(c_gap);
    burst(c_short);
    for (int i = 0; i < 4; i++) begin
      quiet(c_gap);
      if (i == bad_bit) burst(bad_len);
      else              burst(cmd[i] ? c_long : c_short);
    end
  endtask

  task automatic send_packet(input logic [3:0] cmd);
    burst(c_start);
    send_data(cmd, -1, 0);
    quiet(c_tail);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    IR_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  int vb;
  int eb;
  int end_cyc;
  int lat;

  initial begin
    RESET = 1'b1;
    IR_IN = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("rst_command", 32'(COMMAND), 32'h0);
    check_eq("rst_valid", 32'(PACKET_VALID), 32'h0);
    check_eq("rst_error", 32'(PACKET_ERROR), 32'h0);
    check_eq("rst_busy", 32'(BUSY), 32'h0);
    RESET = 1'b0;
    quiet(5);

    // Single packet 1001
    vb = valid_cnt; eb = err_cnt;
    burst(c_start);
    quiet(5);
    check_eq("busy_mid_packet", 32'(BUSY), 32'h1);
    send_data(4'b1001, -1, 0);
    quiet(c_tail);
    check_eq("p1001_valid_cnt", 32'(valid_cnt - vb), 32'd1);
    check_eq("p1001_err_cnt", 32'(err_cnt - eb), 32'd0);
    check_eq("p1001_command", 32'(COMMAND), 32'h9);
    check_eq("p1001_busy_after", 32'(BUSY), 32'h0);

    // Back-to-back 0001, 0110
    vb = valid_cnt; eb = err_cnt;
    send_packet(4'b0001);
    send_packet(4'b0110);
    check_eq("b2b_valid_cnt", 32'(valid_cnt - vb), 32'd2);
    check_eq("b2b_first_cmd", log_at(vb), 32'h1);
    check_eq("b2b_second_cmd", log_at(vb + 1), 32'h6);
    check_eq("b2b_err_cnt", 32'(err_cnt - eb), 32'd0);

    // Short start burst is noise: no strobes, COMMAND stays 0
    do_reset();
    quiet(5);
    vb = valid_cnt; eb = err_cnt;
    burst(60);
    send_data(4'b1111, -1, 0);
    quiet(c_tail);
    check_eq("noise_valid_cnt", 32'(valid_cnt - vb), 32'd0);
    check_eq("noise_err_cnt", 32'(err_cnt - eb), 32'd0);
    check_eq("noise_command", 32'(COMMAND), 32'h0);

    // Data burst between ranges, then a clean 0100 packet
    vb = valid_cnt; eb = err_cnt;
    burst(c_start);
    send_data(4'b0000, 2, 32);
    quiet(c_tail);
    check_eq("midrange_err_cnt", 32'(err_cnt - eb), 32'd1);
    check_eq("midrange_valid_cnt", 32'(valid_cnt - vb), 32'd0);
    send_packet(4'b0100);
    check_eq("after_err_valid_cnt", 32'(valid_cnt - vb), 32'd1);
    check_eq("after_err_command", 32'(COMMAND), 32'h4);

    // Gap timeout after a valid start
    vb = valid_cnt; eb = err_cnt;
    burst(c_start);
    end_cyc = cyc;
    quiet(70);
    quiet(5);
    lat = last_err_cyc - end_cyc;
    check_eq("gap_err_cnt", 32'(err_cnt - eb), 32'd1);
    check_eq("gap_err_latency_ok", 32'((lat >= 244) && (lat <= 260)), 32'd1);
    check_eq("gap_valid_cnt", 32'(valid_cnt - vb), 32'd0);
    check_eq("gap_command_held", 32'(COMMAND), 32'h4);

    // Start burst where data bit 0 is expected: error, then resync decodes
    vb = valid_cnt; eb = err_cnt;
    burst(c_start);
    quiet(c_gap);
    burst(c_short);
    quiet(c_gap);
    burst(c_start);
    send_data(4'b1010, -1, 0);
    quiet(c_tail);
    check_eq("resync_err_cnt", 32'(err_cnt - eb), 32'd1);
    check_eq("resync_valid_cnt", 32'(valid_cnt - vb), 32'd1);
    check_eq("resync_command", 32'(COMMAND), 32'hA);

    // Reset in the gap after data bit 1
    burst(c_start);
    quiet(c_gap);
    burst(c_short);
    quiet(c_gap);
    burst(c_long);
    quiet(c_gap);
    burst(c_long);
    quiet(10);
    vb = valid_cnt; eb = err_cnt;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check_eq("midrst_command", 32'(COMMAND), 32'h0);
    check_eq("midrst_valid", 32'(PACKET_VALID), 32'h0);
    check_eq("midrst_error", 32'(PACKET_ERROR), 32'h0);
    check_eq("midrst_busy", 32'(BUSY), 32'h0);
    quiet(40);
    send_packet(4'b0011);
    check_eq("postrst_valid_cnt", 32'(valid_cnt - vb), 32'd1);
    check_eq("postrst_err_cnt", 32'(err_cnt - eb), 32'd0);
    check_eq("postrst_command", 32'(COMMAND), 32'h3);
`ifdef IR_DECODER_STATS_EN
    check_eq("stats_good", 32'(GOOD_COUNT), 32'd1);
    check_eq("stats_error", 32'(ERROR_COUNT), 32'd0);
`endif

    check_eq("valid_error_overlap", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
